// File: rtl/i2s_adc_receiver_if.sv
// I2S receiver bus: serial inputs from the external ADC and the parallel
// sample outputs toward the synthesis/effects pipeline.
// Optional macro I2S_RX_FRAME_CHECK_EN adds the sticky frame_error flag.
interface i2s_adc_receiver_if #(
    parameter int BIT_WIDTH = 16
);
    logic                 i2s_bit_clock;
    logic                 i2s_left_right_clock;
    logic                 i2s_data;
    logic [BIT_WIDTH-1:0] left_sample;
    logic [BIT_WIDTH-1:0] right_sample;
    logic                 sample_valid;
`ifdef I2S_RX_FRAME_CHECK_EN
    logic                 frame_error;

    modport master (
        output i2s_bit_clock, i2s_left_right_clock, i2s_data,
        input  left_sample, right_sample, sample_valid, frame_error
    );
    modport slave (
        input  i2s_bit_clock, i2s_left_right_clock, i2s_data,
        output left_sample, right_sample, sample_valid, frame_error
    );
`else
    modport master (
        output i2s_bit_clock, i2s_left_right_clock, i2s_data,
        input  left_sample, right_sample, sample_valid
    );
    modport slave (
        input  i2s_bit_clock, i2s_left_right_clock, i2s_data,
        output left_sample, right_sample, sample_valid
    );
`endif
endinterface

// File: rtl/i2s_adc_receiver.sv
// Slave-mode Philips I2S receiver. BCLK/WS/SD are oversampled in the
// clock_16_934_400 domain; nothing is clocked by the external bit clock.
// A left+right pair is presented with a one-cycle sample_valid strobe.
// Optional macro I2S_RX_FRAME_CHECK_EN: adds a sticky frame_error output
// flagging any checked slot whose length differs from BIT_WIDTH.
module i2s_adc_receiver #(
    // Matches the system audio word width (16 in the current build).
    parameter int BIT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clock_16_934_400,
    input  logic           reset_l,
    i2s_adc_receiver_if.slave bus
);
    localparam int CNT_W = $clog2(BIT_WIDTH + 2);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_FULL = cnt_t'(BIT_WIDTH);
    localparam cnt_t CNT_SAT  = cnt_t'(BIT_WIDTH + 1);

    logic [1:0]             rst_pipe;
    logic                   rst_n;
    logic [SYNC_STAGES-1:0] bclk_sync, ws_sync, data_sync;
    logic                   bclk_prev;
    logic                   bclk_s, ws_s, data_s, rise, boundary;

    logic [BIT_WIDTH-1:0]   shift_reg, shift_next, aligned;
    cnt_t                   bit_cnt, cnt_inc;
    logic                   slot_bad;
    logic                   ws_prev, armed, slot_armed, left_ok;
    logic [BIT_WIDTH-1:0]   left_pend, right_pend;
    logic                   fire;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
        if (!reset_l) rst_pipe <= '0;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    // Synchronise the three external I2S lines and keep last BCLK level.
    always_ff @(posedge clock_16_934_400 or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync <= '0;
            ws_sync   <= '0;
            data_sync <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bus.i2s_bit_clock};
            ws_sync   <= {ws_sync[SYNC_STAGES-2:0], bus.i2s_left_right_clock};
            data_sync <= {data_sync[SYNC_STAGES-2:0], bus.i2s_data};
            bclk_prev <= bclk_sync[SYNC_STAGES-1];
        end
    end

    assign bclk_s   = bclk_sync[SYNC_STAGES-1];
    assign ws_s     = ws_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign rise     = bclk_s & ~bclk_prev;
    assign boundary = rise & (ws_s != ws_prev);

    // Next shift/count values and the MSB-aligned word of a closing slot.
    always_comb begin
        cnt_inc    = (bit_cnt == CNT_SAT) ? CNT_SAT : bit_cnt + cnt_t'(1);
        shift_next = (bit_cnt < CNT_FULL) ? {shift_reg[BIT_WIDTH-2:0], data_s}
                                          : shift_reg;
        // cnt_inc counts the LSB being taken on this edge; short slots are
        // left-justified so the received MSB lands in the word MSB.
        aligned    = shift_next;
        if (cnt_inc < CNT_FULL)
            aligned = shift_next << (CNT_FULL - cnt_inc);
        slot_bad   = (cnt_inc != CNT_FULL);
    end

    // Per-slot deserialiser: shift on BCLK rise, restart at WS boundary.
    always_ff @(posedge clock_16_934_400 or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            ws_prev    <= 1'b0;
            armed      <= 1'b0;
            slot_armed <= 1'b0;
        end else if (rise) begin
            if (boundary) begin
                shift_reg  <= '0;
                bit_cnt    <= '0;
                ws_prev    <= ws_s;
                armed      <= 1'b1;
                // The slot starting now is trusted only if framing was
                // already established before this boundary.
                slot_armed <= armed;
            end else begin
                shift_reg  <= shift_next;
                bit_cnt    <= cnt_inc;
            end
        end
    end

    // Frame assembly: hold the left word, fire when its right partner closes.
    always_ff @(posedge clock_16_934_400 or negedge rst_n) begin
        if (!rst_n) begin
            left_pend  <= '0;
            right_pend <= '0;
            left_ok    <= 1'b0;
            fire       <= 1'b0;
        end else begin
            fire <= 1'b0;
            if (boundary) begin
                if (!ws_prev) begin
                    left_pend <= aligned;
                    left_ok   <= slot_armed;
                end else begin
                    if (left_ok) right_pend <= aligned;
                    fire    <= left_ok;
                    left_ok <= 1'b0;
                end
            end
        end
    end

    // Output register: both channels update together with the strobe.
    always_ff @(posedge clock_16_934_400 or negedge rst_n) begin
        if (!rst_n) begin
            bus.left_sample  <= '0;
            bus.right_sample <= '0;
            bus.sample_valid <= 1'b0;
        end else begin
            bus.sample_valid <= fire;
            if (fire) begin
                bus.left_sample  <= left_pend;
                bus.right_sample <= right_pend;
            end
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    // Sticky malformed-slot flag for trusted slots; cleared only by reset.
    always_ff @(posedge clock_16_934_400 or negedge rst_n) begin
        if (!rst_n)
            bus.frame_error <= 1'b0;
        else if (boundary && slot_armed && slot_bad)
            bus.frame_error <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: table of frames plus hand-written
// reset, stopped-BCLK and latency sequences. BCLK is 6 low + 6 high clocks.
module tb_i2s_adc_receiver;
    localparam int BW = 16;

    logic clock_16_934_400 = 1'b0;
    logic reset_l = 1'b0;

    i2s_adc_receiver_if #(.BIT_WIDTH(BW)) bus ();

    i2s_adc_receiver #(.BIT_WIDTH(BW), .SYNC_STAGES(2)) dut (
        .clock_16_934_400 (clock_16_934_400),
        .reset_l          (reset_l),
        .bus              (bus)
    );

    always #5 clock_16_934_400 = ~clock_16_934_400;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int pulse_cnt = 0;
    int pulse_cyc = 0;
    int hold_viol = 0;
    logic [BW-1:0] held_l = '0;
    logic [BW-1:0] held_r = '0;

    typedef struct {
        logic [31:0] left;
        int          left_bits;
        logic [31:0] right;
        int          right_bits;
        logic [BW-1:0] exp_left;
        logic [BW-1:0] exp_right;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    always @(posedge clock_16_934_400) cyc <= cyc + 1;

    // Pulse recorder and between-pulse stability monitor.
    always @(negedge clock_16_934_400) begin
        if (!reset_l) begin
            held_l = '0;
            held_r = '0;
        end else if (bus.sample_valid) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_cyc = cyc;
            held_l = bus.left_sample;
            held_r = bus.right_sample;
        end else if (bus.left_sample !== held_l || bus.right_sample !== held_r) begin
            hold_viol = hold_viol + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic ws, input logic d);
        @(negedge clock_16_934_400);
        bus.i2s_bit_clock = 1'b0;
        bus.i2s_left_right_clock = ws;
        bus.i2s_data = d;
        repeat (5) @(negedge clock_16_934_400);
        @(negedge clock_16_934_400);
        bus.i2s_bit_clock = 1'b1;
        last_rise_cyc = cyc;
        repeat (5) @(negedge clock_16_934_400);
    endtask

    // One slot of n bits on channel ch; the LSB goes out after WS flips.
    task automatic send_slot(input logic ch, input logic [31:0] word, input int n);
        for (int i = n - 1; i >= 1; i--) send_bit(ch, word[i]);
        send_bit(!ch, word[0]);
    endtask

    task automatic send_frame(input logic [31:0] l, input int nl, input logic [31:0] r, input int nr);
        send_slot(1'b0, l, nl);
        send_slot(1'b1, r, nr);
    endtask

    initial begin
        int pc0;
        int prev_pulse;
        logic [31:0] rword;

        vecs[0] = '{32'hA5C3, 16, 32'h1234, 16, 16'hA5C3, 16'h1234, 1'b0};
        vecs[1] = '{32'h0001, 16, 32'h8000, 16, 16'h0001, 16'h8000, 1'b0};
        vecs[2] = '{32'h7FFF, 16, 32'hFFFF, 16, 16'h7FFF, 16'hFFFF, 1'b0};
        vecs[3] = '{32'h0000, 16, 32'h5555, 16, 16'h0000, 16'h5555, 1'b0};
        vecs[4] = '{32'h3FFFC, 18, 32'h00C3, 16, 16'hFFFF, 16'h00C3, 1'b1};
        vecs[5] = '{32'h3FFF, 14, 32'h00FF, 16, 16'hFFFC, 16'h00FF, 1'b1};

        bus.i2s_bit_clock = 1'b0;
        bus.i2s_left_right_clock = 1'b0;
        bus.i2s_data = 1'b0;

        repeat (4) @(negedge clock_16_934_400);
        check("reset left", bus.left_sample, 0);
        check("reset right", bus.right_sample, 0);
        check("reset valid", bus.sample_valid, 0);
`ifdef I2S_RX_FRAME_CHECK_EN
        check("reset frame_error", bus.frame_error, 0);
`endif
        #2 reset_l = 1'b1;
        repeat (4) @(negedge clock_16_934_400);

        // Dummy frame only arms the framer.
        send_frame(32'hDEAD, 16, 32'hBEEF, 16);
        check("dummy frame pulses", pulse_cnt, 0);

        prev_pulse = 0;
        for (int k = 0; k < 6; k++) begin
            pc0 = pulse_cnt;
            send_frame(vecs[k].left, vecs[k].left_bits, vecs[k].right, vecs[k].right_bits);
            check($sformatf("v%0d pulse count", k), pulse_cnt - pc0, 1);
            check($sformatf("v%0d left", k), bus.left_sample, vecs[k].exp_left);
            check($sformatf("v%0d right", k), bus.right_sample, vecs[k].exp_right);
            check($sformatf("v%0d latency", k), pulse_cyc - last_rise_cyc, 4);
            if (k > 0)
                check($sformatf("v%0d pulse gap", k), pulse_cyc - prev_pulse,
                      (vecs[k].left_bits + vecs[k].right_bits) * 12);
`ifdef I2S_RX_FRAME_CHECK_EN
            check($sformatf("v%0d frame_error", k), bus.frame_error, vecs[k].exp_err);
`endif
            prev_pulse = pulse_cyc;
        end

        // Reset in the middle of a right slot.
        rword = 32'h2222;
        send_slot(1'b0, 32'h1111, 16);
        for (int i = 15; i >= 10; i--) send_bit(1'b1, rword[i]);
        @(negedge clock_16_934_400);
        bus.i2s_bit_clock = 1'b0;
        #2 reset_l = 1'b0;
        #1;
        check("midreset left", bus.left_sample, 0);
        check("midreset right", bus.right_sample, 0);
        check("midreset valid", bus.sample_valid, 0);
`ifdef I2S_RX_FRAME_CHECK_EN
        check("midreset frame_error", bus.frame_error, 0);
`endif
        repeat (3) @(negedge clock_16_934_400);
        #2 reset_l = 1'b1;
        pc0 = pulse_cnt;
        for (int i = 9; i >= 1; i--) send_bit(1'b1, rword[i]);
        send_bit(1'b0, rword[0]);
        check("partial frame no pulse", pulse_cnt - pc0, 0);
        send_frame(32'hBEEF, 16, 32'hCAFE, 16);
        check("post-reset pulse count", pulse_cnt - pc0, 1);
        check("post-reset left", bus.left_sample, 16'hBEEF);
        check("post-reset right", bus.right_sample, 16'hCAFE);
`ifdef I2S_RX_FRAME_CHECK_EN
        check("post-reset frame_error", bus.frame_error, 0);
`endif

        // BCLK frozen high while WS and data wiggle.
        pc0 = pulse_cnt;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock_16_934_400);
            if (i % 5 == 0) bus.i2s_left_right_clock = ~bus.i2s_left_right_clock;
            bus.i2s_data = 1'($urandom);
        end
        check("static bclk no pulse", pulse_cnt - pc0, 0);
        check("static bclk left", bus.left_sample, 16'hBEEF);
        check("static bclk right", bus.right_sample, 16'hCAFE);
        send_frame(32'h0F0F, 16, 32'hF0F0, 16);
        check("resume pulse count", pulse_cnt - pc0, 1);
        check("resume left", bus.left_sample, 16'h0F0F);
        check("resume right", bus.right_sample, 16'hF0F0);
        check("resume latency", pulse_cyc - last_rise_cyc, 4);

        repeat (20) @(negedge clock_16_934_400);
        check("outputs held between pulses", hold_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
